imem_boot_loader: RTL and testbench

Program loader sitting directly upstream of the single-cycle MIPS `processor`. It receives a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, writes them into instruction memory, and verifies an XOR checksum. The processor is held in reset until a program has loaded and verified. On success the loader releases the processor's `rst` and goes idle.

---
 rtl/imem_boot_loader_pkg.sv | 15 +
 rtl/imem_boot_loader_byte_assembler.sv | 41 ++++
 rtl/imem_boot_loader.sv | 120 ++++++++++++
 tb/tb_imem_boot_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_LOAD = 3'd1,
        ST_CHK  = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_byte_assembler.sv
// Little-endian byte-to-word assembler: 2-bit lane counter and shift register.
module byte_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        lane_q;
    logic [1:0]        lane_d;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_d;

    // Bytes enter at the top, so the first byte ends up in [7:0].
    always_comb begin
        lane_d     = lane_q;
        shift_d    = shift_q;
        word_valid = 1'b0;
        word       = {byte_data, shift_q[WORD_W-1:8]};
        if (accept) begin
            lane_d     = lane_q + 2'd1;
            shift_d    = word;
            word_valid = (lane_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a counted, checksummed program into imem and releases the CPU.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] count_q, count_d;
    logic [WORD_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [15:0]       wl_q, wl_d;

    logic              accept;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] idx_next;

    assign byte_ready = (state_q == ST_HDR) ||
                        (state_q == ST_LOAD) ||
                        (state_q == ST_CHK);
    assign accept     = byte_valid && byte_ready;

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept),
        .byte_data  (byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    assign idx_next = idx_q + 1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wl_d    = wl_q;
        if (word_valid) begin
            case (state_q)
                ST_HDR: begin
                    count_d = word;
                    if (word > WORD_W'(DEPTH_WORDS))
                        state_d = ST_ERR;
                    else if (word == '0)
                        state_d = ST_CHK;
                    else
                        state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_W'({idx_q[WORD_W-3:0], 2'b00});
                    wdata_d = word;
                    acc_d   = acc_q ^ word;
                    idx_d   = idx_next;
                    wl_d    = wl_q + 16'd1;
                    if (idx_next == count_q)
                        state_d = ST_CHK;
                end
                ST_CHK: begin
                    state_d = (word == acc_q) ? ST_RUN : ST_ERR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HDR;
            count_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wl_q    <= wl_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = wl_q;
    assign done         = (state_q == ST_RUN);
    assign cpu_rst      = (state_q != ST_RUN);
    assign error        = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks = 0;
    int failures = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          base;

    imem_boot_loader #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            if (max_gap > 0) gap($urandom_range(0, max_gap));
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ready"}, 32'(byte_ready), 32'd1);
        chk({pfx, "_we"}, 32'(imem_we), 32'd0);
        chk({pfx, "_addr"}, imem_addr, 32'd0);
        chk({pfx, "_wdata"}, imem_wdata, 32'd0);
        chk({pfx, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_error"}, 32'(error), 32'd0);
        chk({pfx, "_wl"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        // Reset values
        do_reset();
        chk_reset_vals("rst0");

        // Normal load: 0x20080005 ^ 0x20090007 ^ 0x01095020 = 0x01085022
        base = wa.size();
        send_word(32'd3, 0);
        chk("n_hdr_ready", 32'(byte_ready), 32'd1);
        send_word(32'h20080005, 0);
        chk("n_w0_we", 32'(imem_we), 32'd1);
        chk("n_w0_addr", imem_addr, 32'h0);
        chk("n_w0_data", imem_wdata, 32'h20080005);
        chk("n_w0_wl", 32'(words_loaded), 32'd1);
        gap(1);
        chk("n_w0_we_drop", 32'(imem_we), 32'd0);
        send_word(32'h20090007, 0);
        send_word(32'h01095020, 0);
        send_byte(8'h22);
        send_byte(8'h50);
        send_byte(8'h08);
        chk("n_pre_done", 32'(done), 32'd0);
        chk("n_pre_cpu_rst", 32'(cpu_rst), 32'd1);
        send_byte(8'h01);
        chk("n_done", 32'(done), 32'd1);
        chk("n_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("n_ready", 32'(byte_ready), 32'd0);
        chk("n_wl", 32'(words_loaded), 32'd3);
        chk("n_nwr", 32'(wa.size() - base), 32'd3);
        if (wa.size() - base == 3) begin
            chk("n_a0", wa[base], 32'h0);
            chk("n_a1", wa[base+1], 32'h4);
            chk("n_a2", wa[base+2], 32'h8);
            chk("n_d0", wd[base], 32'h20080005);
            chk("n_d1", wd[base+1], 32'h20090007);
            chk("n_d2", wd[base+2], 32'h01095020);
        end
        // Bytes offered in RUN are ignored
        send_word(32'hFFFFFFFF, 0);
        chk("run_ign_done", 32'(done), 32'd1);
        chk("run_ign_nwr", 32'(wa.size() - base), 32'd3);

        // Checksum mismatch
        do_reset();
        chk_reset_vals("rst1");
        base = wa.size();
        send_word(32'd3, 0);
        send_word(32'h20080005, 0);
        send_word(32'h20090007, 0);
        send_word(32'h01095020, 0);
        send_word(32'h00000000, 0);
        chk("m_error", 32'(error), 32'd1);
        chk("m_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("m_done", 32'(done), 32'd0);
        chk("m_ready", 32'(byte_ready), 32'd0);
        chk("m_nwr", 32'(wa.size() - base), 32'd3);

        // Oversize count: 1025
        do_reset();
        base = wa.size();
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h00);
        chk("o_pre_error", 32'(error), 32'd0);
        send_byte(8'h00);
        chk("o_error", 32'(error), 32'd1);
        chk("o_ready", 32'(byte_ready), 32'd0);
        chk("o_cpu_rst", 32'(cpu_rst), 32'd1);
        send_word(32'h12345678, 0);
        chk("o_nwr", 32'(wa.size() - base), 32'd0);
        chk("o_wl", 32'(words_loaded), 32'd0);

        // Empty program
        do_reset();
        base = wa.size();
        send_word(32'd0, 0);
        chk("e_hdr_ready", 32'(byte_ready), 32'd1);
        chk("e_hdr_done", 32'(done), 32'd0);
        send_word(32'd0, 0);
        chk("e_done", 32'(done), 32'd1);
        chk("e_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("e_wl", 32'(words_loaded), 32'd0);
        chk("e_nwr", 32'(wa.size() - base), 32'd0);

        // Full depth: words 0..1023 XOR to 0
        do_reset();
        base = wa.size();
        send_word(32'd1024, 0);
        for (int k = 0; k < 1024; k++) send_word(32'(k), 0);
        chk("f_last_addr", imem_addr, 32'hFFC);
        chk("f_last_data", imem_wdata, 32'd1023);
        send_word(32'd0, 0);
        chk("f_done", 32'(done), 32'd1);
        chk("f_wl", 32'(words_loaded), 32'd1024);
        chk("f_nwr", 32'(wa.size() - base), 32'd1024);

        // Stalls, then reset mid-word
        do_reset();
        base = wa.size();
        send_word(32'd2, 3);
        send_word(32'hCAFEF00D, 3);
        gap(4);
        chk("s_we_idle", 32'(imem_we), 32'd0);
        send_byte(8'h11);
        gap(2);
        send_byte(8'h22);
        chk("s_nwr", 32'(wa.size() - base), 32'd1);
        if (wa.size() - base == 1) begin
            chk("s_a0", wa[base], 32'h0);
            chk("s_d0", wd[base], 32'hCAFEF00D);
        end
        chk("s_wl", 32'(words_loaded), 32'd1);
        do_reset();
        chk_reset_vals("rst2");
        base = wa.size();
        send_word(32'd1, 2);
        send_word(32'hDEADBEEF, 2);
        send_word(32'hDEADBEEF, 2);
        chk("r_done", 32'(done), 32'd1);
        chk("r_nwr", 32'(wa.size() - base), 32'd1);
        if (wa.size() - base == 1) begin
            chk("r_a0", wa[base], 32'h0);
            chk("r_d0", wd[base], 32'hDEADBEEF);
        end

        // Reset from RUN re-holds the processor
        do_reset();
        chk_reset_vals("rst3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
